mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter.sv | 140 ++++++++++++++
 tb/tb_mult_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// Purpose: two-requester round-robin front end for one shared signed multiplier core.
// Latency: grant -> ISSUE -> core latency -> RESP; rsp_valid rises one cycle after mul_done.
// Backpressure: one operation in flight; RESP holds until the owner's rsp_ready, no new grant before then.
module mult_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req0_valid,
  output logic                        req0_ready,
  input  logic signed [WIDTH-1:0]     req0_x,
  input  logic signed [WIDTH-1:0]     req0_y,
  input  logic                        req1_valid,
  output logic                        req1_ready,
  input  logic signed [WIDTH-1:0]     req1_x,
  input  logic signed [WIDTH-1:0]     req1_y,
  output logic                        rsp0_valid,
  input  logic                        rsp0_ready,
  output logic                        rsp1_valid,
  input  logic                        rsp1_ready,
  output logic signed [2*WIDTH-1:0]   rsp_product,
  output logic                        rsp_overflow,
  output logic                        rsp_error,
  output logic                        mul_start,
  output logic signed [WIDTH-1:0]     mul_x,
  output logic signed [WIDTH-1:0]     mul_y,
  input  logic                        mul_done,
  input  logic        [2*WIDTH-1:0]   mul_product,
  input  logic                        mul_overflow
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                    state_q, state_d;
  // owner_q doubles as last_grant: it names the requester of the current/most recent operation
  logic                      owner_q, owner_d;
  logic signed [WIDTH-1:0]   x_q, x_d;
  logic signed [WIDTH-1:0]   y_q, y_d;
  logic        [2*WIDTH-1:0] prod_q, prod_d;
  logic                      ovf_q, ovf_d;
  logic                      err_q, err_d;
  logic        [CW-1:0]      cnt_q, cnt_d;
  logic                      pick;
  logic                      grant0, grant1;

  // Next-state, arbitration and timeout logic
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    x_d     = x_q;
    y_d     = y_q;
    prod_d  = prod_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    pick    = 1'b0;
    grant0  = 1'b0;
    grant1  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          // Contention goes to whoever did not win last; otherwise the lone requester wins
          if (req0_valid && req1_valid) pick = ~owner_q;
          else                          pick = req1_valid;
          grant0  = ~pick;
          grant1  = pick;
          owner_d = pick;
          x_d     = pick ? req1_x : req0_x;
          y_d     = pick ? req1_y : req0_y;
          // Counter starts from zero as ISSUE begins, so in WAIT it equals cycles since start
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = cnt_q + CW'(1);
        state_d = WAIT;
      end
      WAIT: begin
        // A done on the timeout cycle still wins and delivers the real result
        if (mul_done) begin
          prod_d  = mul_product;
          ovf_d   = mul_overflow;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q >= CW'(TIMEOUT - 1)) begin
          prod_d  = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (owner_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously; requester 0 wins first after reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= 1'b1;
      x_q     <= '0;
      y_q     <= '0;
      prod_q  <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      x_q     <= x_d;
      y_q     <= y_d;
      prod_q  <= prod_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Grant handshake is combinational in IDLE; gated so reset forces it low immediately
  assign req0_ready   = grant0 & rst;
  assign req1_ready   = grant1 & rst;
  assign mul_start    = (state_q == ISSUE);
  assign mul_x        = x_q;
  assign mul_y        = y_q;
  assign rsp0_valid   = (state_q == RESP) && !owner_q;
  assign rsp1_valid   = (state_q == RESP) &&  owner_q;
  assign rsp_product  = prod_q;
  assign rsp_overflow = ovf_q;
  assign rsp_error    = err_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: directed requests, a scripted multiplier core and a response scoreboard.
// Stimulus pushes expected responses; a monitor pops them on each response handshake.
// The core model answers each mul_start with a hand-given product after a scripted latency.
module tb_mult_arbiter;

  localparam int W = 32;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  req0_valid, req0_ready, req1_valid, req1_ready;
  logic signed [W-1:0]   req0_x, req0_y, req1_x, req1_y;
  logic                  rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic signed [2*W-1:0] rsp_product;
  logic                  rsp_overflow, rsp_error;
  logic                  mul_start, mul_done, mul_overflow;
  logic signed [W-1:0]   mul_x, mul_y;
  logic        [2*W-1:0] mul_product;

  mult_arbiter #(.WIDTH(W), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_product(rsp_product), .rsp_overflow(rsp_overflow), .rsp_error(rsp_error),
    .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y),
    .mul_done(mul_done), .mul_product(mul_product), .mul_overflow(mul_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                    port;
    logic signed [2*W-1:0] prod;
    logic                  ovf;
    logic                  err;
    int                    lat;   // cycles from ISSUE to first rsp_valid
  } exp_t;

  typedef struct {
    logic signed [W-1:0]   x;
    logic signed [W-1:0]   y;
    logic signed [2*W-1:0] prod;
    logic                  ovf;
    int                    lat;   // posedges until done; negative means never
  } core_t;

  exp_t  exp_q[$];
  core_t core_q[$];
  int    pass_cnt = 0;
  int    total_cnt = 0;
  int    cyc = 0;
  int    issue_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", nm, $signed(act), $signed(expv));
  endtask

  task automatic fail(input string nm);
    total_cnt++;
    $display("FAIL %s", nm);
  endtask

  task automatic push_exp(input int p, input logic signed [2*W-1:0] pr, input logic o,
                          input logic e, input int l);
    exp_t t;
    t.port = p; t.prod = pr; t.ovf = o; t.err = e; t.lat = l;
    exp_q.push_back(t);
  endtask

  task automatic push_core(input logic signed [W-1:0] x, input logic signed [W-1:0] y,
                           input logic signed [2*W-1:0] pr, input logic o, input int l);
    core_t t;
    t.x = x; t.y = y; t.prod = pr; t.ovf = o; t.lat = l;
    core_q.push_back(t);
  endtask

  // Present one request and hold it until granted (bounded)
  task automatic send(input int p, input logic signed [W-1:0] x, input logic signed [W-1:0] y);
    int n;
    logic rdy;
    @(posedge clk); #1;
    if (p == 0) begin req0_valid = 1'b1; req0_x = x; req0_y = y; end
    else        begin req1_valid = 1'b1; req1_x = x; req1_y = y; end
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 1000) begin
      @(negedge clk);
      n++;
      rdy = (p == 0) ? req0_ready : req1_ready;
    end
    if (!rdy) fail($sformatf("grant_timeout port%0d", p));
    @(posedge clk); #1;
    if (p == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail("response_timeout");
    repeat (2) @(negedge clk);
  endtask

  // Scripted multiplier core: checks operands at start, answers after the scripted latency
  initial begin
    core_t ce;
    mul_done = 1'b0; mul_product = '0; mul_overflow = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && mul_start === 1'b1) begin
        issue_cyc = cyc;
        if (core_q.size() == 0) begin
          fail("unexpected_mul_start");
        end else begin
          ce = core_q.pop_front();
          chk("mul_x", mul_x, ce.x);
          chk("mul_y", mul_y, ce.y);
          if (ce.lat > 0) begin
            repeat (ce.lat) @(posedge clk);
            #1 mul_done = 1'b1; mul_product = ce.prod; mul_overflow = ce.ovf;
            @(posedge clk);
            #1 mul_done = 1'b0; mul_product = '0; mul_overflow = 1'b0;
          end
        end
      end
    end
  end

  // Response monitor: latency on arrival, stability while held, scoreboard on handshake
  logic                  in_rsp = 1'b0;
  logic signed [2*W-1:0] h_prod;
  logic                  h_ovf, h_err;
  always @(negedge clk) begin
    exp_t e;
    if (rst !== 1'b1) begin
      in_rsp = 1'b0;
    end else if (rsp0_valid || rsp1_valid) begin
      if (rsp0_valid && rsp1_valid) fail("both_rsp_valid");
      if (!in_rsp) begin
        in_rsp = 1'b1;
        h_prod = rsp_product; h_ovf = rsp_overflow; h_err = rsp_error;
        if (exp_q.size() != 0) chk("rsp_latency", 64'(cyc - issue_cyc), 64'(exp_q[0].lat));
      end else begin
        chk("rsp_hold_product", rsp_product, h_prod);
        chk("rsp_hold_flags", {rsp_overflow, rsp_error}, {h_ovf, h_err});
      end
      if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
        in_rsp = 1'b0;
        if (exp_q.size() == 0) begin
          fail("unexpected_response");
        end else begin
          e = exp_q.pop_front();
          chk("rsp_port", rsp1_valid ? 1 : 0, 64'(e.port));
          chk("rsp_product", rsp_product, e.prod);
          chk("rsp_overflow", rsp_overflow, e.ovf);
          chk("rsp_error", rsp_error, e.err);
        end
      end
    end else begin
      in_rsp = 1'b0;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req0_ready"}, req0_ready, 0);
    chk({tag, "_req1_ready"}, req1_ready, 0);
    chk({tag, "_rsp0_valid"}, rsp0_valid, 0);
    chk({tag, "_rsp1_valid"}, rsp1_valid, 0);
    chk({tag, "_mul_start"}, mul_start, 0);
    chk({tag, "_flags"}, {rsp_overflow, rsp_error}, 0);
    chk({tag, "_rsp_product"}, rsp_product, 0);
    chk({tag, "_mul_xy"}, {mul_x, mul_y}, 0);
  endtask

  initial begin
    logic seen;
    int   n;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_x = '0; req0_y = '0; req1_x = '0; req1_y = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1 rst = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1 chk_all_zero("reset");
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Simultaneous pair after reset: requester 0 first
    push_core(12, 5, 60, 0, 2);  push_exp(0, 60, 0, 0, 3);
    push_core(-3, 21, -63, 0, 3); push_exp(1, -63, 0, 0, 4);
    fork
      send(0, 12, 5);
      send(1, -3, 21);
    join
    wait_idle();

    // Single request
    push_core(2, -5, -10, 0, 1); push_exp(0, -10, 0, 0, 2);
    send(0, 2, -5);
    wait_idle();

    // Second simultaneous pair: requester 1 first since 0 won last
    push_core(100, 3, 300, 0, 2); push_exp(1, 300, 0, 0, 3);
    push_core(7, -8, -56, 0, 1);  push_exp(0, -56, 0, 0, 2);
    fork
      send(0, 7, -8);
      send(1, 100, 3);
    join
    wait_idle();

    // Overflow pass-through
    push_core(-4, 32'sh8000_0000, 64'sd8589934592, 1, 4);
    push_exp(1, 64'sd8589934592, 1, 0, 5);
    send(1, -4, 32'sh8000_0000);
    wait_idle();

    // Timeout: core never answers; response exactly 64 cycles after start
    push_core(9, 9, 81, 0, -1); push_exp(0, 0, 0, 1, 64);
    send(0, 9, 9);
    wait_idle();
    push_core(3, -7, -21, 0, 2); push_exp(1, -21, 0, 0, 3);
    send(1, 3, -7);
    wait_idle();

    // Backpressure on requester 0 while requester 1 waits
    rsp0_ready = 1'b0;
    push_core(6, 7, 42, 0, 1);  push_exp(0, 42, 0, 0, 2);
    push_core(-2, -2, 4, 0, 1); push_exp(1, 4, 0, 0, 2);
    send(0, 6, 7);
    fork
      send(1, -2, -2);
      begin
        n = 0;
        while (!rsp0_valid && n < 100) begin @(negedge clk); n++; end
        if (!rsp0_valid) fail("bp_rsp0_never_valid");
        repeat (10) begin
          @(negedge clk);
          chk("bp_req1_ready_low", req1_ready, 0);
          chk("bp_rsp0_valid_held", rsp0_valid, 1);
        end
        @(posedge clk); #1 rsp0_ready = 1'b1;
      end
    join
    wait_idle();

    // Reset while waiting on the core; the late done must be ignored
    push_core(5, 5, 25, 0, 20);
    send(0, 5, 5);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1 chk_all_zero("midop_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid || mul_start) seen = 1'b1;
    end
    chk("late_done_ignored", seen, 0);

    // After release, requester 0 wins a tie again
    push_core(-1, -1, 1, 0, 1); push_exp(0, 1, 0, 0, 2);
    push_core(4, 4, 16, 0, 1);  push_exp(1, 16, 0, 0, 2);
    fork
      send(0, -1, -1);
      send(1, 4, 4);
    join
    wait_idle();

    chk("queues_drained", 64'(exp_q.size() + core_q.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
